// File: rtl/pll_clock_manager.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pll_clock_manager                                                |
// | Brief   : PLL lock qualification, reset sequencing and phase-aligned       |
// |           clock-enable strobes. Optional LOCK_LOSS_COUNT_EN adds a         |
// |           saturating count of lock losses seen in RUN.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pll_clock_manager #(
    parameter int                      NUM_CH             = 4,
    parameter int                      DIV_W              = 16,
    parameter logic [NUM_CH*DIV_W-1:0] DIVISORS           = {16'd2, 16'd12, 16'd1200, 16'd120},
    parameter int                      SYNC_STAGES        = 2,
    parameter int                      LOCK_STABLE_CYCLES = 1024,
    parameter int                      RST_HOLD_CYCLES    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pll_locked,
    output logic              rst_out,
    output logic              ready,
    output logic [NUM_CH-1:0] ce
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [7:0]        lock_loss_count
`endif
);

    localparam int c_QMAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                   : RST_HOLD_CYCLES;
    localparam int c_QW   = $clog2(c_QMAX + 1);
    localparam logic [c_QW-1:0] c_STABLE_LAST = c_QW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_QW-1:0] c_HOLD_LAST   = c_QW'(RST_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_HOLD_RST  = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_QW-1:0]        r_qual_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rst_out;
    logic                   r_ready;
    logic                   w_locked_s;
    logic                   w_run_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // Registered outputs and the dividers follow the state the FSM is about to enter,
    // so they line up exactly with the state flop.
    assign w_run_next = w_locked_s &&
                        ((r_state == S_RUN) ||
                         ((r_state == S_HOLD_RST) && (r_qual_cnt == c_HOLD_LAST)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_WAIT_LOCK;
            r_qual_cnt <= '0;
            r_rst_out  <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            r_rst_out <= !w_run_next;
            r_ready   <= w_run_next;
            case (r_state)
                S_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        r_state    <= S_STABLE;
                        r_qual_cnt <= '0;
                    end
                end
                S_STABLE: begin
                    if (!w_locked_s) begin
                        r_state    <= S_WAIT_LOCK;
                        r_qual_cnt <= '0;
                    end else if (r_qual_cnt == c_STABLE_LAST) begin
                        r_state    <= S_HOLD_RST;
                        r_qual_cnt <= '0;
                    end else begin
                        r_qual_cnt <= r_qual_cnt + 1'b1;
                    end
                end
                S_HOLD_RST: begin
                    if (!w_locked_s) begin
                        r_state    <= S_WAIT_LOCK;
                        r_qual_cnt <= '0;
                    end else if (r_qual_cnt == c_HOLD_LAST) begin
                        r_state    <= S_RUN;
                        r_qual_cnt <= '0;
                    end else begin
                        r_qual_cnt <= r_qual_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!w_locked_s) begin
                        r_state <= S_WAIT_LOCK;
                    end
                end
                default: begin
                    r_state    <= S_WAIT_LOCK;
                    r_qual_cnt <= '0;
                end
            endcase
        end
    end

    assign rst_out = r_rst_out;
    assign ready   = r_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [DIV_W-1:0] c_DIV  = DIVISORS[i*DIV_W +: DIV_W];
        // A zero divisor behaves as divide-by-one.
        localparam logic [DIV_W-1:0] c_LAST = (c_DIV == '0) ? '0 : DIV_W'(c_DIV - 1'b1);

        logic [DIV_W-1:0] r_div_cnt;
        logic             r_ce;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_div_cnt <= '0;
                r_ce      <= 1'b0;
            end else if (!w_run_next) begin
                r_div_cnt <= '0;
                r_ce      <= 1'b0;
            end else if (r_div_cnt == c_LAST) begin
                r_div_cnt <= '0;
                r_ce      <= 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
                r_ce      <= 1'b0;
            end
        end

        assign ce[i] = r_ce;
    end

`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0] r_loss_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_loss_cnt <= 8'd0;
        end else if ((r_state == S_RUN) && !w_locked_s && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_count = r_loss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_clock_manager.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pll_clock_manager                                             |
// | Brief   : Directed self-checking bench for pll_clock_manager.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pll_clock_manager;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 16;

    logic              clock;
    logic              reset;
    logic              pll_locked;
    logic              rst_out;
    logic              ready;
    logic [NUM_CH-1:0] ce;
`ifdef LOCK_LOSS_COUNT_EN
    logic [7:0]        lock_loss_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pll_clock_manager #(
        .NUM_CH             (NUM_CH),
        .DIV_W              (DIV_W),
        .DIVISORS           ({16'd5, 16'd3, 16'd1}),
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .RST_HOLD_CYCLES    (4)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .rst_out    (rst_out),
        .ready      (ready),
        .ce         (ce)
`ifdef LOCK_LOSS_COUNT_EN
        ,
        .lock_loss_count (lock_loss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] status();
        return 32'({rst_out, ready, ce});
    endfunction

    // From the negedge where pll_locked (or reset release) takes effect: RUN on edge 15.
    task automatic relock_seq(input string tag);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clock);
            if (n < 15) check_val(tag, status(), 32'b1_0_000);
            else        check_val(tag, status(), 32'b0_1_001);
        end
    endtask

    // Called at the sample point of RUN cycle 1.
    task automatic run_ce(input int ncyc);
        logic [2:0] exp;
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) @(negedge clock);
            exp = {(c % 5) == 0, (c % 3) == 0, 1'b1};
            check_val("ce_run", 32'(ce), 32'(exp));
        end
    endtask

    task automatic loss_cycle();
        pll_locked = 1'b0;
        repeat (3) @(negedge clock);
        pll_locked = 1'b1;
        repeat (15) @(negedge clock);
    endtask

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b1;
        repeat (2) @(negedge clock);
        check_val("reset_state", status(), 32'b1_0_000);
`ifdef LOCK_LOSS_COUNT_EN
        check_val("loss_reset", 32'(lock_loss_count), 32'd0);
`endif

        // Power-up qualification and divider phases
        reset = 1'b0;
        relock_seq("powerup");
        run_ce(15);

        // Lock loss in RUN, then full re-qualification
        pll_locked = 1'b0;
        @(negedge clock);
        check_val("run_loss_e1", 32'(ready), 32'd1);
        @(negedge clock);
        check_val("run_loss_e2", 32'(ready), 32'd1);
        @(negedge clock);
        check_val("run_loss_e3", status(), 32'b1_0_000);
        repeat (2) @(negedge clock);
        check_val("wait_lock", status(), 32'b1_0_000);
        pll_locked = 1'b1;
        relock_seq("relock");
        run_ce(10);

        // One-cycle glitch while STABLE at qual_cnt=5 restarts qualification
        pll_locked = 1'b0;
        repeat (5) @(negedge clock);
        pll_locked = 1'b1;
        repeat (6) @(negedge clock);
        pll_locked = 1'b0;
        @(negedge clock);
        pll_locked = 1'b1;
        for (int n = 8; n <= 22; n++) begin
            @(negedge clock);
            if (n < 22) check_val("stable_glitch", status(), 32'b1_0_000);
            else        check_val("stable_glitch", status(), 32'b0_1_001);
        end

        // Asynchronous reset mid-RUN
        @(negedge clock);
        check_val("pre_async", 32'(ready), 32'd1);
        #2 reset = 1'b1;
        #1 check_val("async_reset", status(), 32'b1_0_000);
        @(negedge clock);
        reset = 1'b0;
        relock_seq("post_reset");
        run_ce(6);

`ifdef LOCK_LOSS_COUNT_EN
        check_val("loss_after_reset", 32'(lock_loss_count), 32'd0);
        loss_cycle();
        loss_cycle();
        pll_locked = 1'b0;
        repeat (3) @(negedge clock);
        check_val("loss_three", 32'(lock_loss_count), 32'd3);
        // Loss while in HOLD_RST is not counted
        pll_locked = 1'b1;
        repeat (10) @(negedge clock);
        pll_locked = 1'b0;
        repeat (4) @(negedge clock);
        check_val("hold_loss_ready", 32'(ready), 32'd0);
        check_val("hold_loss_cnt", 32'(lock_loss_count), 32'd3);
        pll_locked = 1'b1;
        repeat (15) @(negedge clock);
        check_val("hold_relock", 32'(ready), 32'd1);
        for (int i = 1; i <= 260; i++) begin
            loss_cycle();
            if (i == 251) check_val("loss_254", 32'(lock_loss_count), 32'd254);
        end
        check_val("loss_sat", 32'(lock_loss_count), 32'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
